// File: rtl/fifo_wcheck_arb_pkg.sv
// Shared types for fifo_wcheck_arb: FSM state encoding and the check-timeout counter width.
package fifo_wcheck_arb_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHECK      = 3'd1,
    CHECK_WAIT = 3'd2,
    WRITE      = 3'd3,
    DONE       = 3'd4
  } state_t;

  localparam int TMO_CNT_WIDTH = 16;

  function automatic logic [TMO_CNT_WIDTH-1:0] tmo_last(input int timeout_cyc);
    return TMO_CNT_WIDTH'(timeout_cyc - 1);
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter.sv
// Combinational round-robin grant: first set request at or after rr_ptr, wrapping.
module fifo_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 grant_any
);

  logic [IDX_WIDTH-1:0] cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]   cand_req;

  // Rotate the request vector so position 0 is the current round-robin head.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign cand_idx[gi] = IDX_WIDTH'((int'(rr_ptr) + gi) % NUM_REQ);
    assign cand_req[gi] = req[cand_idx[gi]];
  end

  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        grant_idx = cand_idx[k];
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wcheck_arb.sv
// Round-robin write-side controller for the checked FIFO with duplicate dropping.
// Optional statistics counters are built when FIFO_WCHECK_ARB_STATS_EN is defined.
module fifo_wcheck_arb
  import fifo_wcheck_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REQ     = 4,
  parameter int IDX_WIDTH   = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dat,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          ack_dup,
  output logic                          busy,
  output logic                          timeout_err,
  output logic                          ff_wren,
  output logic [DATA_WIDTH-1:0]         ff_wdat,
  input  logic                          ff_full,
  input  logic                          ff_empty,
  output logic                          ff_check_req,
  output logic [DATA_WIDTH-1:0]         ff_check_dat,
  input  logic                          ff_check_res,
  input  logic                          ff_check_vld,
  output logic [CNT_WIDTH-1:0]          stat_wr_cnt,
  output logic [CNT_WIDTH-1:0]          stat_dup_cnt
);

  state_t                   state_reg;
  logic [IDX_WIDTH-1:0]     rr_ptr_reg;
  logic [IDX_WIDTH-1:0]     idx_reg;
  logic [DATA_WIDTH-1:0]    data_reg;
  logic                     dup_reg;
  logic                     timeout_err_reg;
  logic [TMO_CNT_WIDTH-1:0] tmo_cnt_reg;

  logic [IDX_WIDTH-1:0]     grant_idx;
  logic                     grant_any;
  logic [DATA_WIDTH-1:0]    req_word [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
    assign req_word[gi] = req_dat[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  fifo_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_reg),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      idx_reg         <= '0;
      data_reg        <= '0;
      dup_reg         <= 1'b0;
      timeout_err_reg <= 1'b0;
      tmo_cnt_reg     <= '0;
    end else begin
      timeout_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            idx_reg   <= grant_idx;
            data_reg  <= req_word[grant_idx];
            dup_reg   <= 1'b0;
            state_reg <= ff_empty ? WRITE : CHECK;
          end
        end
        CHECK: begin
          tmo_cnt_reg <= '0;
          state_reg   <= CHECK_WAIT;
        end
        CHECK_WAIT: begin
          if (ff_check_vld) begin
            dup_reg   <= ff_check_res;
            state_reg <= ff_check_res ? DONE : WRITE;
          end else if (tmo_cnt_reg == tmo_last(TIMEOUT_CYC)) begin
            // No answer from the FIFO: treat as a miss and write anyway.
            timeout_err_reg <= 1'b1;
            state_reg       <= WRITE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_CNT_WIDTH'(1);
          end
        end
        WRITE: begin
          if (!ff_full) state_reg <= DONE;
        end
        DONE: begin
          rr_ptr_reg <= (idx_reg == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : idx_reg + IDX_WIDTH'(1);
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
    assign ack[gi] = (state_reg == DONE) && (idx_reg == IDX_WIDTH'(gi));
  end

  assign ack_dup      = (state_reg == DONE) && dup_reg;
  assign busy         = (state_reg != IDLE);
  assign timeout_err  = timeout_err_reg;
  // Write enable must see the live full flag so a stalled write fires the cycle full drops.
  assign ff_wren      = (state_reg == WRITE) && !ff_full;
  assign ff_wdat      = data_reg;
  assign ff_check_req = (state_reg == CHECK);
  assign ff_check_dat = data_reg;

`ifdef FIFO_WCHECK_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] wr_cnt_reg;
  logic [CNT_WIDTH-1:0] dup_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_reg  <= '0;
      dup_cnt_reg <= '0;
    end else begin
      if (ff_wren && !(&wr_cnt_reg))
        wr_cnt_reg <= wr_cnt_reg + CNT_WIDTH'(1);
      if (ack_dup && !(&dup_cnt_reg))
        dup_cnt_reg <= dup_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign stat_wr_cnt  = wr_cnt_reg;
  assign stat_dup_cnt = dup_cnt_reg;
`else
  assign stat_wr_cnt  = '0;
  assign stat_dup_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wcheck_arb.sv
// Self-checking bench for fifo_wcheck_arb: FIFO contents and check responder modelled with a queue.
module tb_fifo_wcheck_arb;

  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int IW  = 2;
  localparam int TMO = 64;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_dat;
  logic [NR-1:0]     ack;
  logic              ack_dup, busy, timeout_err, ff_wren;
  logic [DW-1:0]     ff_wdat, ff_check_dat;
  logic              ff_full, ff_empty, ff_check_req, ff_check_res, ff_check_vld;
  logic [CW-1:0]     stat_wr_cnt, stat_dup_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] fifo_q [$];
  int mdl_ptr = 0;
  int mdl_wr  = 0;
  int mdl_dup = 0;

  always #5 clk = ~clk;

  fifo_wcheck_arb #(
    .DATA_WIDTH (DW), .NUM_REQ (NR), .IDX_WIDTH (IW), .TIMEOUT_CYC (TMO), .CNT_WIDTH (CW)
  ) dut (
    .clk (clk), .rst (rst), .req (req), .req_dat (req_dat), .ack (ack), .ack_dup (ack_dup),
    .busy (busy), .timeout_err (timeout_err), .ff_wren (ff_wren), .ff_wdat (ff_wdat),
    .ff_full (ff_full), .ff_empty (ff_empty), .ff_check_req (ff_check_req),
    .ff_check_dat (ff_check_dat), .ff_check_res (ff_check_res), .ff_check_vld (ff_check_vld),
    .stat_wr_cnt (stat_wr_cnt), .stat_dup_cnt (stat_dup_cnt)
  );

  function automatic bit in_fifo(input logic [DW-1:0] x);
    foreach (fifo_q[i]) if (fifo_q[i] == x) return 1'b1;
    return 1'b0;
  endfunction

  // One full transaction. d = check response delay in cycles (0 = never answer),
  // f = cycles of ff_full once WRITE is entered. Cycle 0 is the grant cycle.
  task automatic do_txn(input logic [NR-1:0] reqv, input logic [NR*DW-1:0] datv, input int d,
                        input int f, input bit drop_req, input string tag, output int gnt);
    int g, n, fstart, cyc, exp_ack_cyc, exp_wr_cyc, exp_to_cyc, exp_chk;
    int wr_seen, wr_cyc, chk_seen, to_seen, to_cyc, both, vld_cyc, ack_cyc;
    bit empty0, hit, exp_wr, got_ack, res_val, busy1;
    logic [DW-1:0] ed, wr_dat, chk_dat;
    logic [NR-1:0] ack_val, exp_ack;
    logic dup_val;
    logic [CW-1:0] exp_sw, exp_sd;

    g = -1;
    for (int k = 0; k < NR; k++) if (g < 0 && reqv[(mdl_ptr + k) % NR]) g = (mdl_ptr + k) % NR;
    ed          = datv[g*DW +: DW];
    empty0      = (fifo_q.size() == 0);
    hit         = !empty0 && (d > 0) && in_fifo(ed);
    exp_wr      = !hit;
    exp_chk     = empty0 ? 0 : 1;
    n           = empty0 ? 0 : ((d > 0) ? d : TMO);
    fstart      = empty0 ? 1 : 2 + n;
    exp_wr_cyc  = fstart + f;
    exp_ack_cyc = hit ? 2 + n : exp_wr_cyc + 1;
    exp_to_cyc  = (!empty0 && d == 0) ? 2 + n : -1;
    exp_ack     = '0;
    exp_ack[g]  = 1'b1;

    wr_seen = 0; wr_cyc = -1; chk_seen = 0; to_seen = 0; to_cyc = -1; both = 0;
    vld_cyc = -1; ack_cyc = -1; res_val = 1'b0; got_ack = 1'b0; busy1 = 1'b0;
    wr_dat = '0; chk_dat = '0; ack_val = '0; dup_val = 1'b0;

    @(posedge clk); #1;
    cyc = 0;
    req = reqv; req_dat = datv; ff_empty = empty0; ff_full = 1'b0;
    ff_check_vld = 1'b0; ff_check_res = 1'b0;
    while (!got_ack && cyc < 300) begin
      @(negedge clk);
      if (cyc == 1) busy1 = busy;
      if (ff_wren && ff_check_req) both++;
      if (ff_wren) begin
        wr_seen++; wr_cyc = cyc; wr_dat = ff_wdat; fifo_q.push_back(ff_wdat);
      end
      if (ff_check_req) begin
        chk_seen++; chk_dat = ff_check_dat;
        vld_cyc = (d > 0) ? cyc + d : -1;
        res_val = in_fifo(ff_check_dat);
      end
      if (timeout_err) begin to_seen++; to_cyc = cyc; end
      if (ack != '0) begin
        got_ack = 1'b1; ack_val = ack; dup_val = ack_dup; ack_cyc = cyc;
      end else begin
        @(posedge clk); #1;
        cyc++;
        if (drop_req) req = '0;
        ff_full      = (cyc >= fstart) && (cyc < fstart + f);
        ff_check_vld = (cyc == vld_cyc);
        ff_check_res = (cyc == vld_cyc) && res_val;
        ff_empty     = (fifo_q.size() == 0);
      end
    end

    gnt = -1;
    for (int i = 0; i < NR; i++) if (ack_val[i]) gnt = i;
    $display("[TB] txn %s req=%b grant=%0d dup=%0d ack_cyc=%0d", tag, reqv, gnt, dup_val, ack_cyc);

    tests_run++;
    if (!got_ack) begin
      tests_failed++; $display("FAIL %s ack_timeout: no ack within 300 cycles", tag);
    end
    tests_run++;
    if (ack_val !== exp_ack) begin
      tests_failed++; $display("FAIL %s ack_vec: got %b expected %b", tag, ack_val, exp_ack);
    end
    tests_run++;
    if (dup_val !== hit) begin
      tests_failed++; $display("FAIL %s ack_dup: got %b expected %b", tag, dup_val, hit);
    end
    tests_run++;
    if (ack_cyc != exp_ack_cyc) begin
      tests_failed++; $display("FAIL %s ack_latency: got %0d expected %0d", tag, ack_cyc, exp_ack_cyc);
    end
    tests_run++;
    if (busy1 !== 1'b1) begin
      tests_failed++; $display("FAIL %s busy: got %b expected 1", tag, busy1);
    end
    tests_run++;
    if (wr_seen != int'(exp_wr)) begin
      tests_failed++; $display("FAIL %s wr_count: got %0d expected %0d", tag, wr_seen, exp_wr);
    end
    if (exp_wr) begin
      tests_run++;
      if (wr_dat !== ed || wr_cyc != exp_wr_cyc) begin
        tests_failed++;
        $display("FAIL %s wr_data: got %h@%0d expected %h@%0d", tag, wr_dat, wr_cyc, ed, exp_wr_cyc);
      end
    end
    tests_run++;
    if (chk_seen != exp_chk) begin
      tests_failed++; $display("FAIL %s check_count: got %0d expected %0d", tag, chk_seen, exp_chk);
    end
    if (exp_chk != 0) begin
      tests_run++;
      if (chk_dat !== ed) begin
        tests_failed++; $display("FAIL %s check_dat: got %h expected %h", tag, chk_dat, ed);
      end
    end
    tests_run++;
    if (to_seen != ((exp_to_cyc >= 0) ? 1 : 0) || to_cyc != exp_to_cyc) begin
      tests_failed++;
      $display("FAIL %s timeout_err: got %0d pulses @%0d expected @%0d", tag, to_seen, to_cyc, exp_to_cyc);
    end
    tests_run++;
    if (both != 0) begin
      tests_failed++; $display("FAIL %s wren_and_check: got %0d overlapping cycles expected 0", tag, both);
    end

    mdl_wr += int'(exp_wr);
`ifdef FIFO_WCHECK_ARB_STATS_EN
    exp_sw = CW'(mdl_wr);
    exp_sd = CW'(mdl_dup);
`else
    exp_sw = '0;
    exp_sd = '0;
`endif
    tests_run++;
    if (stat_wr_cnt !== exp_sw || stat_dup_cnt !== exp_sd) begin
      tests_failed++;
      $display("FAIL %s stats: got wr=%0d dup=%0d expected wr=%0d dup=%0d",
               tag, stat_wr_cnt, stat_dup_cnt, exp_sw, exp_sd);
    end
    mdl_dup += int'(hit);
    mdl_ptr = (g + 1) % NR;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_dat = '0; ff_full = 1'b0; ff_empty = 1'b1;
    ff_check_vld = 1'b0; ff_check_res = 1'b0;
    #1;
    tests_run++;
    if ({ack, ack_dup, busy, timeout_err, ff_wren, ff_wdat, ff_check_req, ff_check_dat,
         stat_wr_cnt, stat_dup_cnt} !== '0) begin
      tests_failed++; $display("FAIL reset_outputs: ack=%b busy=%b wdat=%h expected all zero", ack, busy, ff_wdat);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_empty_write();
    int g;
    fifo_q.delete();
    do_txn(4'b0001, {96'h0, 32'h0000_00A5}, 2, 0, 1'b0, "empty_write", g);
  endtask

  task automatic test_check_hit();
    int g;
    fifo_q.delete(); fifo_q.push_back(32'h11); fifo_q.push_back(32'hA5);
    do_txn(4'b0010, {32'h1, 32'h2, 32'hA5, 32'h3}, 2, 0, 1'b0, "check_hit", g);
  endtask

  task automatic test_check_miss();
    int g;
    fifo_q.delete(); fifo_q.push_back(32'h11);
    do_txn(4'b1000, {32'hBEEF_0001, 96'h0}, 3, 0, 1'b1, "check_miss", g);
  endtask

  task automatic test_fairness();
    int g;
    int order [5] = '{0, 1, 2, 3, 0};
    for (int t = 0; t < 5; t++) begin
      fifo_q.delete();
      do_txn(4'b1111, {$urandom(), $urandom(), $urandom(), $urandom()}, 1, 0, 1'b0, "fairness", g);
      tests_run++;
      if (g != order[t]) begin
        tests_failed++; $display("FAIL fairness_order[%0d]: got %0d expected %0d", t, g, order[t]);
      end
    end
  endtask

  task automatic test_full_stall();
    int g;
    fifo_q.delete();
    do_txn(4'b0001, {96'h0, 32'h5A5A_0F0F}, 1, 10, 1'b0, "full_stall", g);
  endtask

  task automatic test_timeout();
    int g;
    fifo_q.delete(); fifo_q.push_back(32'h77);
    do_txn(4'b0100, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 0, 1'b0, "timeout", g);
  endtask

  task automatic test_reset_mid();
    int ack_cnt, wr_cnt, chk_cnt;
    @(posedge clk); #1;
    req = 4'b0100; req_dat = {$urandom(), $urandom(), $urandom(), $urandom()};
    ff_empty = 1'b0; ff_full = 1'b0; ff_check_vld = 1'b0; ff_check_res = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL reset_mid_busy: got %b expected 1", busy);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({ack, ack_dup, busy, timeout_err, ff_wren, ff_wdat, ff_check_req, ff_check_dat,
         stat_wr_cnt, stat_dup_cnt} !== '0) begin
      tests_failed++; $display("FAIL reset_mid_outputs: ack=%b busy=%b chkdat=%h expected all zero", ack, busy, ff_check_dat);
    end
    @(posedge clk); #1;
    rst = 1'b0; req = '0;
    ack_cnt = 0; wr_cnt = 0; chk_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack != '0) ack_cnt++;
      if (ff_wren) wr_cnt++;
      if (ff_check_req) chk_cnt++;
    end
    $display("[TB] txn reset_mid acks=%0d writes=%0d checks=%0d", ack_cnt, wr_cnt, chk_cnt);
    tests_run++;
    if (ack_cnt != 0 || wr_cnt != 0 || chk_cnt != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_abort: got acks=%0d writes=%0d checks=%0d expected 0", ack_cnt, wr_cnt, chk_cnt);
    end
    mdl_ptr = 0; mdl_wr = 0; mdl_dup = 0;
  endtask

  task automatic test_random();
    int g, d, f;
    logic [NR-1:0] rv;
    logic [NR*DW-1:0] dv;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0 || fifo_q.size() > 20) fifo_q.delete();
      rv = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        if (fifo_q.size() > 0 && $urandom_range(0, 2) == 0)
          dv[i*DW +: DW] = fifo_q[$urandom_range(0, fifo_q.size() - 1)];
        else
          dv[i*DW +: DW] = $urandom();
      end
      d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      f = int'($urandom_range(0, 3));
      do_txn(rv, dv, d, f, 1'($urandom_range(0, 1)), "random", g);
    end
  endtask

  task automatic test_final_stats();
    logic [CW-1:0] exp_sw, exp_sd;
    @(posedge clk); #1;
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef FIFO_WCHECK_ARB_STATS_EN
    exp_sw = CW'(mdl_wr);
    exp_sd = CW'(mdl_dup);
`else
    exp_sw = '0;
    exp_sd = '0;
`endif
    tests_run++;
    if (stat_wr_cnt !== exp_sw || stat_dup_cnt !== exp_sd || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL final_stats: got wr=%0d dup=%0d busy=%b expected wr=%0d dup=%0d busy=0",
               stat_wr_cnt, stat_dup_cnt, busy, exp_sw, exp_sd);
    end
  endtask

  initial begin
    test_reset();
    test_empty_write();
    test_check_hit();
    test_check_miss();
    test_fairness();
    test_full_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    test_final_stats();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
